// File: rtl/axi_led_pwm_ctrl_if.sv
// rtl/axi_led_pwm_ctrl_if.sv - AXI4-Lite register bus bundle for the LED PWM controller
interface axi_led_pwm_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_led_pwm_ctrl.sv
// rtl/axi_led_pwm_ctrl.sv - AXI4-Lite LED controller (off/on/blink/PWM per channel); `define LED_STATUS_EN adds STATUS readback
module axi_led_pwm_ctrl #(
    parameter int NUM_LEDS           = 8,
    parameter int PWM_WIDTH          = 8,
    parameter int PRESCALE_W         = 16,
    parameter int BLINK_LOG2         = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    axi_led_pwm_ctrl_if.slave       s_axi,
    output logic [NUM_LEDS-1:0]     led_o
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

    logic                    en;
    logic [2*NUM_LEDS-1:0]   mode;
    logic [PRESCALE_W-1:0]   prescale;
    logic [PWM_WIDTH-1:0]    duty        [NUM_LEDS];
    logic [PWM_WIDTH-1:0]    active_duty [NUM_LEDS];
    logic [PRESCALE_W-1:0]   presc_cnt;
    logic [PWM_WIDTH-1:0]    pwm_cnt;
    logic [BLINK_LOG2-1:0]   blink_cnt;
    logic                    en_q;
    logic                    aw_ready_q, ar_ready_q, bvalid_q, rvalid_q;
    logic [31:0]             rdata_q;
    logic [IDX_W-1:0]        widx, ridx;
    logic                    wr_fire, rd_fire, tb_clr, tick, period_end;
    logic [31:0]             rd_word, wr_old, wr_mask, wr_merged;
    logic [NUM_LEDS-1:0]     led_next;
    logic                    unused_bits;

    assign widx          = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ridx          = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = aw_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign wr_fire    = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire    = ar_ready_q && s_axi.arvalid;
    assign tb_clr     = wr_fire && (widx == '0) && s_axi.wstrb[0] && s_axi.wdata[1];
    assign tick       = en && (presc_cnt >= prescale);
    assign period_end = tick && (pwm_cnt == PWM_MAX);

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0], wr_merged};

    // Word view of a register as seen by the bus; also the base for byte-lane merges.
    function automatic logic [31:0] reg_word(input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w = '0;
        if (int'(idx) == 0) begin
            w[0] = en;
        end else if (int'(idx) == 1) begin
            w[2*NUM_LEDS-1:0] = mode;
        end else if (int'(idx) == 2) begin
            w[PRESCALE_W-1:0] = prescale;
`ifdef LED_STATUS_EN
        end else if (int'(idx) == 3) begin
            w[16 +: PWM_WIDTH]  = pwm_cnt;
            w[NUM_LEDS-1:0]     = led_o;
`endif
        end else begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                if (int'(idx) == 4 + k) w[PWM_WIDTH-1:0] = duty[k];
            end
        end
        return w;
    endfunction

    always_comb begin
        rd_word   = reg_word(ridx);
        wr_old    = reg_word(widx);
        wr_mask   = {{8{s_axi.wstrb[3]}}, {8{s_axi.wstrb[2]}}, {8{s_axi.wstrb[1]}}, {8{s_axi.wstrb[0]}}};
        wr_merged = (wr_old & ~wr_mask) | (s_axi.wdata & wr_mask);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            en         <= 1'b0;
            mode       <= '0;
            prescale   <= '0;
            for (int k = 0; k < NUM_LEDS; k++) duty[k] <= '0;
        end else begin
            aw_ready_q <= !aw_ready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
            if (wr_fire)           bvalid_q <= 1'b1;
            else if (s_axi.bready) bvalid_q <= 1'b0;

            ar_ready_q <= !ar_ready_q && s_axi.arvalid && !rvalid_q;
            if (rd_fire) begin
                rdata_q  <= rd_word;
                rvalid_q <= 1'b1;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_fire) begin
                if (int'(widx) == 0) en       <= wr_merged[0];
                if (int'(widx) == 1) mode     <= wr_merged[2*NUM_LEDS-1:0];
                if (int'(widx) == 2) prescale <= wr_merged[PRESCALE_W-1:0];
                for (int k = 0; k < NUM_LEDS; k++) begin
                    if (int'(widx) == 4 + k) duty[k] <= wr_merged[PWM_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (en) begin
                case (mode[2*k +: 2])
                    2'b00:   led_next[k] = 1'b0;
                    2'b01:   led_next[k] = 1'b1;
                    2'b10:   led_next[k] = blink_cnt[BLINK_LOG2-1];
                    default: led_next[k] = (pwm_cnt < active_duty[k]);
                endcase
            end
        end
    end

    // Shared timebase; active duty copies reload only where a period can start cleanly.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            en_q      <= 1'b0;
            led_o     <= '0;
            for (int k = 0; k < NUM_LEDS; k++) active_duty[k] <= '0;
        end else begin
            en_q  <= en;
            led_o <= led_next;
            if (tb_clr) begin
                presc_cnt <= '0;
                pwm_cnt   <= '0;
                blink_cnt <= '0;
            end else if (en) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
                if (tick)       pwm_cnt   <= pwm_cnt + PWM_WIDTH'(1);
                if (period_end) blink_cnt <= blink_cnt + BLINK_LOG2'(1);
            end
            if (period_end || tb_clr || (en && !en_q)) begin
                for (int k = 0; k < NUM_LEDS; k++) active_duty[k] <= duty[k];
            end
        end
    end
endmodule
